// File: rtl/dac_pkg.sv
// Shared DAC definitions: code width, serial frame length
// and the output-FSM state encoding.
package dac_pkg;

    localparam int DAC_DATA_W    = 12;
    localparam int DAC_FRAME_CYC = 49;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/dac_sync_fifo.sv
// Synchronous FIFO with registered read port and an
// occupancy count for the DAC sample path.
module dac_sync_fifo
    import dac_pkg::*;
#(
    parameter int DATA_W = DAC_DATA_W,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              dropped,
    output logic [ADDR_W:0]   fill_level
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W:0]   rd_cnt;
    logic              do_push;
    logic              do_pop;

    assign fill_level = wr_cnt - rd_cnt;
    assign empty      = (fill_level == '0);
    assign full       = (fill_level == (ADDR_W+1)'(DEPTH));
    assign do_pop     = rd_en && !empty;
    // A pop frees a slot this cycle, so a full FIFO may still accept.
    assign do_push    = wr_en && (!full || do_pop);
    assign dropped    = wr_en && !do_push;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_cnt[ADDR_W-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            rd_data <= '0;
        end else begin
            if (do_push)
                wr_cnt <= wr_cnt + 1'b1;
            if (do_pop) begin
                rd_cnt  <= rd_cnt + 1'b1;
                rd_data <= mem[rd_cnt[ADDR_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// Rate-controlled sample source feeding the DAC7611 serializer:
// FIFO, sample-period divider, output FSM and sticky event flags.
module dac_sample_feeder
    import dac_pkg::*;
#(
    parameter int DATA_W  = DAC_DATA_W,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int DIV_W   = 16,
    parameter int MIN_DIV = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic [ADDR_W:0]   fill_level,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flag_clr,
    output logic              overflow,
    output logic              underrun,
    output logic              late
);

    state_t           state;
    state_t           state_nx;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] clamp_div;
    logic             loaded;
    logic             tick;
    logic             pop;
    logic             empty;
    logic             dropped;
    logic             under_set;
    logic             late_set;

    dac_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (pop),
        .rd_data    (out_data),
        .full       (wr_full),
        .empty      (empty),
        .dropped    (dropped),
        .fill_level (fill_level)
    );

    assign clamp_div = (rate_div < DIV_W'(MIN_DIV)) ?
                       DIV_W'(MIN_DIV) : rate_div;
    assign tick = enable && (cnt == period - DIV_W'(1));

    // Period is sampled only at period boundaries or while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            period <= DIV_W'(MIN_DIV);
            loaded <= 1'b0;
        end else begin
            loaded <= 1'b1;
            if (!loaded || !enable || tick)
                period <= clamp_div;
            if (!enable || tick)
                cnt <= '0;
            else
                cnt <= cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        under_set = 1'b0;
        late_set  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable)
                    state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (!enable) begin
                    state_nx = S_IDLE;
                end else if (tick) begin
                    pop       = !empty;
                    under_set = empty;
                    state_nx  = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                late_set  = tick;
                if (out_ready)
                    state_nx = enable ? S_WAIT : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Set has priority over clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
            late     <= 1'b0;
        end else begin
            overflow <= dropped   | (overflow & ~flag_clr);
            underrun <= under_set | (underrun & ~flag_clr);
            late     <= late_set  | (late & ~flag_clr);
        end
    end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Directed bench for dac_sample_feeder: reset, ordering, rate,
// underrun, overflow, clamp, late and enable-drop handling.
module tb_dac_sample_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] rate_div;
    logic        wr_en;
    logic [11:0] wr_data;
    logic        wr_full;
    logic [4:0]  fill_level;
    logic        out_valid;
    logic [11:0] out_data;
    logic        out_ready;
    logic        flag_clr;
    logic        overflow;
    logic        underrun;
    logic        late;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_last = 0;
    logic seen;

    dac_sample_feeder dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .rate_div   (rate_div),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_full    (wr_full),
        .fill_level (fill_level),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .flag_clr   (flag_clr),
        .overflow   (overflow),
        .underrun   (underrun),
        .late       (late)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n = 0;
        step(1);
        while (out_valid !== 1'b1 && n < bound) begin
            step(1);
            n++;
        end
        check({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic write(input logic [11:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step(1);
        wr_en   = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        rate_div  = 16'd10;
        wr_en     = 1'b0;
        wr_data   = '0;
        out_ready = 1'b0;
        flag_clr  = 1'b0;
        step(3);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_fill", 32'(fill_level), 0);
        check("rst_full", 32'(wr_full), 0);
        check("rst_flags", 32'({overflow, underrun, late}), 0);
        reset = 1'b1;
        step(2);

        // reset while presenting a code
        write(12'h123);
        write(12'h456);
        check("c1_fill2", 32'(fill_level), 2);
        enable = 1'b1;
        wait_valid("c1", 80);
        check("c1_data", 32'(out_data), 32'h123);
        check("c1_fill1", 32'(fill_level), 1);
        step(70);
        check("c1_late", 32'(late), 1);
        check("c1_hold", 32'(out_data), 32'h123);
        reset  = 1'b0;
        enable = 1'b0;
        step(1);
        check("c1_r_valid", 32'(out_valid), 0);
        check("c1_r_fill", 32'(fill_level), 0);
        check("c1_r_data", 32'(out_data), 0);
        check("c1_r_flags", 32'({overflow, underrun, late}), 0);
        reset     = 1'b1;
        rate_div  = 16'd100;
        out_ready = 1'b1;
        step(2);

        // ordered release at 100-cycle period
        write(12'h000);
        write(12'h7FF);
        write(12'hFFF);
        check("c2_fill3", 32'(fill_level), 3);
        enable = 1'b1;
        t_last = cyc;
        wait_valid("c2a", 120);
        check("c2_lat", 32'(cyc - t_last), 100);
        t_last = cyc;
        check("c2_d0", 32'(out_data), 32'h000);
        wait_valid("c2b", 120);
        check("c2_per1", 32'(cyc - t_last), 100);
        t_last = cyc;
        check("c2_d1", 32'(out_data), 32'h7FF);
        wait_valid("c2c", 120);
        check("c2_per2", 32'(cyc - t_last), 100);
        t_last = cyc;
        check("c2_d2", 32'(out_data), 32'hFFF);
        check("c2_nounder", 32'(underrun), 0);

        // underrun re-sends the last code
        wait_valid("c3a", 120);
        check("c3_per", 32'(cyc - t_last), 100);
        t_last = cyc;
        check("c3_resend", 32'(out_data), 32'hFFF);
        check("c3_under", 32'(underrun), 1);
        flag_clr = 1'b1;
        step(1);
        flag_clr = 1'b0;
        check("c3_clr", 32'(underrun), 0);
        wait_valid("c3b", 120);
        check("c3_per2", 32'(cyc - t_last), 100);
        check("c3_resend2", 32'(out_data), 32'hFFF);
        check("c3_under2", 32'(underrun), 1);

        // fill to full, then overflow
        enable   = 1'b0;
        flag_clr = 1'b1;
        step(1);
        flag_clr = 1'b0;
        check("c4_idle", 32'(out_valid), 0);
        check("c4_clr", 32'(underrun), 0);
        for (int i = 0; i < 16; i++)
            write(12'(12'h100 + i));
        check("c4_full", 32'(wr_full), 1);
        check("c4_fill16", 32'(fill_level), 16);
        check("c4_noovf", 32'(overflow), 0);
        write(12'hAAA);
        check("c4_ovf", 32'(overflow), 1);
        check("c4_fill_kept", 32'(fill_level), 16);

        // clamp to 64 cycles, then late tick
        rate_div = 16'd10;
        flag_clr = 1'b1;
        step(1);
        flag_clr = 1'b0;
        check("c5_clr", 32'(overflow), 0);
        enable = 1'b1;
        t_last = cyc;
        wait_valid("c5a", 80);
        check("c5_lat", 32'(cyc - t_last), 64);
        t_last = cyc;
        check("c5_d0", 32'(out_data), 32'h100);
        wait_valid("c5b", 80);
        check("c5_per", 32'(cyc - t_last), 64);
        check("c5_d1", 32'(out_data), 32'h101);
        step(1);
        out_ready = 1'b0;
        wait_valid("c5c", 80);
        check("c5_d2", 32'(out_data), 32'h102);
        check("c5_fill13", 32'(fill_level), 13);
        step(70);
        check("c5_late", 32'(late), 1);
        check("c5_still", 32'(out_valid), 1);
        check("c5_stable", 32'(out_data), 32'h102);
        check("c5_onepop", 32'(fill_level), 13);
        out_ready = 1'b1;
        wait_valid("c5d", 80);
        check("c5_d3", 32'(out_data), 32'h103);
        check("c5_fill12", 32'(fill_level), 12);
        for (int i = 4; i < 16; i++) begin
            wait_valid("c5_drain", 80);
            check("c5_drain_d", 32'(out_data), 32'(12'h100 + i));
        end
        check("c5_empty", 32'(fill_level), 0);
        wait_valid("c5u", 80);
        check("c5_no17th", 32'(out_data), 32'h10F);
        check("c5_under", 32'(underrun), 1);

        // enable dropped while a code is pending
        step(1);
        out_ready = 1'b0;
        wait_valid("c6", 80);
        enable = 1'b0;
        step(10);
        check("c6_hold", 32'(out_valid), 1);
        check("c6_data", 32'(out_data), 32'h10F);
        out_ready = 1'b1;
        step(1);
        check("c6_exit", 32'(out_valid), 0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (out_valid)
                seen = 1'b1;
        end
        check("c6_noticks", 32'(seen), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
